// File: rtl/multi_lane_inverter_pkg.sv
// Shared mode codes, default geometry and lane parity helper for multi_lane_inverter_pipe.
package multi_lane_inverter_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_LANES = 4;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_MASK = 2'b01;
    localparam logic [1:0] MODE_ALL  = 2'b10;
    localparam logic [1:0] MODE_ALT  = 2'b11;

    // Lanes are zero-extended to 64 bits by the caller; zero padding leaves XOR parity unchanged.
    function automatic logic lane_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/multi_lane_inverter_pipe_skid.sv
// inv_skid_buf: generic 2-entry FIFO-ordered valid/ready buffer with registered in_ready.
module inv_skid_buf #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] ent0_q, ent0_d;
    logic [DW-1:0] ent1_q, ent1_d;
    logic          in_ready_q, in_ready_d;
    logic          push, pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = ent0_q;

    // ent0 is always the head, so out_data comes straight from a flop and holds while stalled.
    always_comb begin
        push       = in_valid & in_ready_q;
        pop        = (cnt_q != 2'd0) & out_ready;
        cnt_d      = cnt_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    ent0_d = in_data;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    ent0_d = in_data;
                end else if (push) begin
                    ent1_d = in_data;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    ent0_d = ent1_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
        in_ready_d = (cnt_d < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/multi_lane_inverter_pipe.sv
// Multi-lane selectable inverter with config registers, ALT phase, skid buffer and beat counter.
// Optional per-lane parity output is enabled by defining INV_PARITY_EN.
module multi_lane_inverter_pipe
    import multi_lane_inverter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [LANES-1:0]       cfg_mask,
    input  logic [1:0]             cfg_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       mask_q,
    output logic [1:0]             mode_q,
    output logic [CNT_W-1:0]       beat_cnt
`ifdef INV_PARITY_EN
    ,
    output logic [LANES-1:0]       out_parity
`endif
);

    localparam int unsigned DATA_W = LANES * WIDTH;
`ifdef INV_PARITY_EN
    localparam int unsigned BUF_W = DATA_W + LANES;
`else
    localparam int unsigned BUF_W = DATA_W;
`endif

    logic [LANES-1:0]  mask_d;
    logic [1:0]        mode_d;
    logic              phase_q, phase_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              accept, xfer;
    logic [DATA_W-1:0] proc_data;
    logic [BUF_W-1:0]  buf_in, buf_out;
    logic              inv;

    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign beat_cnt = beat_cnt_q;

    // Lane operation uses the registered mask/mode, so a beat accepted with cfg_we sees the old config.
    always_comb begin
        proc_data = in_data;
        inv       = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            case (mode_q)
                MODE_PASS: inv = 1'b0;
                MODE_MASK: inv = mask_q[i];
                MODE_ALL:  inv = 1'b1;
                MODE_ALT:  inv = mask_q[i] & phase_q;
                default:   inv = 1'b0;
            endcase
            proc_data[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH] ^ {WIDTH{inv}};
        end
    end

`ifdef INV_PARITY_EN
    logic [LANES-1:0] proc_par;

    always_comb begin
        proc_par = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            proc_par[i] = lane_parity(64'(proc_data[i*WIDTH +: WIDTH]));
        end
    end

    assign buf_in     = {proc_par, proc_data};
    assign out_data   = buf_out[DATA_W-1:0];
    assign out_parity = buf_out[BUF_W-1:DATA_W];
`else
    assign buf_in   = proc_data;
    assign out_data = buf_out;
`endif

    always_comb begin
        mask_d     = mask_q;
        mode_d     = mode_q;
        phase_d    = phase_q;
        beat_cnt_d = beat_cnt_q;
        if (cfg_we) begin
            mask_d  = cfg_mask;
            mode_d  = cfg_mode;
            phase_d = 1'b0;
        end else if (accept) begin
            phase_d = ~phase_q;
        end
        if (xfer && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            mode_q     <= MODE_PASS;
            phase_q    <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            phase_q    <= phase_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    inv_skid_buf #(
        .DW (BUF_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (buf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

endmodule

// File: tb/tb_multi_lane_inverter_pipe.sv
// Directed self-checking bench for multi_lane_inverter_pipe (WIDTH=8, LANES=4, CNT_W=4).
module tb_multi_lane_inverter_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cfg_we;
    logic [LANES-1:0]       cfg_mask;
    logic [1:0]             cfg_mode;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       mask_q;
    logic [1:0]             mode_q;
    logic [CNT_W-1:0]       beat_cnt;
`ifdef INV_PARITY_EN
    logic [LANES-1:0]       out_parity;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] mon_q[$];

    multi_lane_inverter_pipe #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_mask  (cfg_mask),
        .cfg_mode  (cfg_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mask_q    (mask_q),
        .mode_q    (mode_q),
        .beat_cnt  (beat_cnt)
`ifdef INV_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so the negedge view matches what the next edge transfers.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) mon_q.push_back(out_data);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic [3:0] m, input logic [1:0] md);
        cfg_we   = 1'b1;
        cfg_mask = m;
        cfg_mode = md;
        cycles(1);
        cfg_we   = 1'b0;
    endtask

    task automatic push_beat(input string tag, input logic [31:0] d);
        logic acc;
        acc      = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = in_ready;
            cycles(1);
        end
        in_valid = 1'b0;
        check({tag, "_accepted"}, 64'(acc), 64'd1);
    endtask

    task automatic send_check(input string tag, input logic [31:0] d, input logic [31:0] exp);
        push_beat(tag, d);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_mask  = '0;
        cfg_mode  = 2'b00;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cycles(3);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_mask", 64'(mask_q), 64'd0);
        check("rst_mode", 64'(mode_q), 64'd0);
        check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        rst_n = 1'b1;
        cycles(1);

        // 1: PASS
        cfg(4'b0000, 2'b00);
        send_check("t1", 32'h12345678, 32'h12345678);
        cycles(1);
        check("t1_beat_cnt", 64'(beat_cnt), 64'd1);

        // 2: MASK lanes 0 and 2
        cfg(4'b0101, 2'b01);
        check("t2_mask_q", 64'(mask_q), 64'h5);
        check("t2_mode_q", 64'(mode_q), 64'h1);
        send_check("t2", 32'h00FF00FF, 32'h00000000);

        // 3: ALT alternates starting with pass
        cfg(4'b1111, 2'b11);
        send_check("t3a", 32'hAAAAAAAA, 32'hAAAAAAAA);
        send_check("t3b", 32'hAAAAAAAA, 32'h55555555);
        send_check("t3c", 32'hAAAAAAAA, 32'hAAAAAAAA);

        // 4: backpressure, three beats through a two-entry buffer
        cfg(4'b0000, 2'b00);
        mon_q.delete();
        out_ready = 1'b0;
        push_beat("t4_b1", 32'h11111111);
        push_beat("t4_b2", 32'h22222222);
        check("t4_in_ready_full", 64'(in_ready), 64'd0);
        in_data  = 32'h33333333;
        in_valid = 1'b1;
        cycles(3);
        check("t4_hold_valid", 64'(out_valid), 64'd1);
        check("t4_hold_data", 64'(out_data), 64'h11111111);
        check("t4_still_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        begin
            logic acc;
            acc = 1'b0;
            for (int i = 0; i < 20 && !acc; i++) begin
                acc = in_ready;
                cycles(1);
            end
            in_valid = 1'b0;
            check("t4_b3_accepted", 64'(acc), 64'd1);
        end
        cycles(5);
        check("t4_out_count", 64'(mon_q.size()), 64'd3);
        if (mon_q.size() == 3) begin
            check("t4_out0", 64'(mon_q[0]), 64'h11111111);
            check("t4_out1", 64'(mon_q[1]), 64'h22222222);
            check("t4_out2", 64'(mon_q[2]), 64'h33333333);
        end
        check("t4_beat_cnt", 64'(beat_cnt), 64'd8);

        // 5: cfg_we coincident with an accept uses the old config
        cfg_we   = 1'b1;
        cfg_mask = 4'b0000;
        cfg_mode = 2'b10;
        in_data  = 32'h0F0F0F0F;
        in_valid = 1'b1;
        check("t5_ready", 64'(in_ready), 64'd1);
        cycles(1);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        check("t5_old_cfg", 64'(out_data), 64'h0F0F0F0F);
        check("t5_mode_q", 64'(mode_q), 64'h2);
        send_check("t5_new_cfg", 32'h0F0F0F0F, 32'hF0F0F0F0);

        // 5b: clear wins over toggle when cfg_we and accept coincide
        cfg_we   = 1'b1;
        cfg_mask = 4'b1111;
        cfg_mode = 2'b11;
        in_data  = 32'h12345678;
        in_valid = 1'b1;
        cycles(1);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        check("t5b_old_all", 64'(out_data), 64'hEDCBA987);
        send_check("t5b_phase0", 32'h12345678, 32'h12345678);
        send_check("t5b_phase1", 32'h12345678, 32'hEDCBA987);
        cycles(2);
        check("t5_beat_cnt", 64'(beat_cnt), 64'd13);

        // 6: async reset with the buffer full
        cfg(4'b0000, 2'b00);
        out_ready = 1'b0;
        push_beat("t6_b1", 32'hDEADBEEF);
        push_beat("t6_b2", 32'hCAFEF00D);
        check("t6_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_in_ready", 64'(in_ready), 64'd1);
        check("t6_rst_beat_cnt", 64'(beat_cnt), 64'd0);
        cycles(1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycles(2);
        check("t6_after_rst_valid", 64'(out_valid), 64'd0);

`ifdef INV_PARITY_EN
        // Lanes 07,00,03,01 (lane0 first) have parities 1,0,0,1.
        send_check("t7_par", 32'h01030007, 32'h01030007);
        check("t7_parity", 64'(out_parity), 64'h9);
`endif

        // Saturation: stream well over 2^CNT_W-1 beats
        in_data  = 32'h5A5A5A5A;
        in_valid = 1'b1;
        cycles(24);
        in_valid = 1'b0;
        cycles(3);
        check("sat_beat_cnt", 64'(beat_cnt), 64'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
